// File: rtl/cpu_trace_buffer.sv
// Purpose   : retirement-trace capture; circular buffer of {pc, instr, result} with
//             PC-match / forced trigger, programmable post-trigger window, frozen readout.
// Latency   : one write per trace_valid cycle; readout returns data 1 cycle after rd_en.
// Backpress.: none; trace stream is sampled every cycle, writes simply stop once DONE.
// Ports     : clk/reset (async, active-high); trace_* retire tap; arm/trig_pc_en/trig_pc/
//             force_trig/post_count trigger control; rd_en/rd_idx -> rd_valid/rd_pc/
//             rd_instr/rd_result readout; armed/done/fill_count/trig_idx status.
module cpu_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trace_valid,
    input  logic [XLEN-1:0] trace_pc,
    input  logic [ILEN-1:0] trace_instr,
    input  logic [XLEN-1:0] trace_result,
    input  logic            arm,
    input  logic            trig_pc_en,
    input  logic [XLEN-1:0] trig_pc,
    input  logic            force_trig,
    input  logic [AW-1:0]   post_count,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_idx,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_pc,
    output logic [ILEN-1:0] rd_instr,
    output logic [XLEN-1:0] rd_result,
    output logic            armed,
    output logic            done,
    output logic [AW:0]     fill_count,
    output logic [AW-1:0]   trig_idx
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t          r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_fill;
    logic [AW-1:0]   r_post_cnt;   // post_count latched at arm
    logic [AW-1:0]   r_post_rem;   // writes still owed after the trigger entry
    logic            r_force_pend; // force_trig seen without a retire, waiting for one
    logic            r_rd_valid;
    logic [XLEN-1:0] r_rd_pc;
    logic [ILEN-1:0] r_rd_instr;
    logic [XLEN-1:0] r_rd_result;

    logic [XLEN-1:0] r_mem_pc     [DEPTH];
    logic [ILEN-1:0] r_mem_instr  [DEPTH];
    logic [XLEN-1:0] r_mem_result [DEPTH];

    logic            w_capturing;
    logic            w_wr_en;
    logic            w_trig;
    logic [AW-1:0]   w_rd_addr;
    logic            w_rd_in_range;

    assign w_capturing   = (r_state == S_ARMED) || (r_state == S_POST);
    // arm wins: the arm cycle never writes, even with a retire present
    assign w_wr_en       = !arm && trace_valid && w_capturing;
    assign w_trig        = trace_valid &&
                           ((trig_pc_en && (trace_pc == trig_pc)) || force_trig || r_force_pend);
    // oldest entry sits fill_count slots behind the write pointer (mod DEPTH)
    assign w_rd_addr     = r_wr_ptr - r_fill[AW-1:0] + rd_idx;
    assign w_rd_in_range = ({1'b0, rd_idx} < r_fill);

    // Trace storage carries no reset; fill_count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_pc[r_wr_ptr]     <= trace_pc;
            r_mem_instr[r_wr_ptr]  <= trace_instr;
            r_mem_result[r_wr_ptr] <= trace_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_post_cnt   <= '0;
            r_post_rem   <= '0;
            r_force_pend <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_pc      <= '0;
            r_rd_instr   <= '0;
            r_rd_result  <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            if (arm) begin
                r_state      <= S_ARMED;
                r_wr_ptr     <= '0;
                r_fill       <= '0;
                r_post_cnt   <= post_count;
                r_post_rem   <= '0;
                r_force_pend <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    r_fill   <= (r_fill == FULL) ? r_fill : r_fill + (AW+1)'(1);
                end
                case (r_state)
                    S_ARMED: begin
                        if (trace_valid) begin
                            if (w_trig) begin
                                r_force_pend <= 1'b0;
                                r_post_rem   <= r_post_cnt;
                                r_state      <= (r_post_cnt == '0) ? S_DONE : S_POST;
                            end
                        end else if (force_trig) begin
                            r_force_pend <= 1'b1;
                        end
                    end
                    S_POST: begin
                        if (trace_valid) begin
                            r_post_rem <= r_post_rem - AW'(1);
                            if (r_post_rem == AW'(1)) begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        if (rd_en) begin
                            r_rd_valid  <= 1'b1;
                            r_rd_pc     <= w_rd_in_range ? r_mem_pc[w_rd_addr]     : '0;
                            r_rd_instr  <= w_rd_in_range ? r_mem_instr[w_rd_addr]  : '0;
                            r_rd_result <= w_rd_in_range ? r_mem_result[w_rd_addr] : '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_valid   = r_rd_valid;
    assign rd_pc      = r_rd_pc;
    assign rd_instr   = r_rd_instr;
    assign rd_result  = r_rd_result;
    assign armed      = w_capturing;
    assign done       = (r_state == S_DONE);
    assign fill_count = r_fill;
    // trigger entry is followed by exactly post_count entries, so it is the
    // (post_count+1)-th newest; only meaningful once frozen
    assign trig_idx   = done ? (r_fill[AW-1:0] - AW'(1) - r_post_cnt) : '0;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Purpose   : directed, self-checking bench for cpu_trace_buffer (DEPTH = 16).
// Latency   : inputs driven 1 time unit after each rising edge; outputs checked there too.
// Backpress.: none; readout expectations queued at rd_en and retired on rd_valid.
module tb_cpu_trace_buffer;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] res;
    } entry_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            trace_valid;
    logic [XLEN-1:0] trace_pc;
    logic [ILEN-1:0] trace_instr;
    logic [XLEN-1:0] trace_result;
    logic            arm;
    logic            trig_pc_en;
    logic [XLEN-1:0] trig_pc;
    logic            force_trig;
    logic [AW-1:0]   post_count;
    logic            rd_en;
    logic [AW-1:0]   rd_idx;
    logic            rd_valid;
    logic [XLEN-1:0] rd_pc;
    logic [ILEN-1:0] rd_instr;
    logic [XLEN-1:0] rd_result;
    logic            armed;
    logic            done;
    logic [AW:0]     fill_count;
    logic [AW-1:0]   trig_idx;

    int errors = 0;
    int checks = 0;
    entry_t sb[$];

    cpu_trace_buffer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_instr(trace_instr),
        .trace_result(trace_result),
        .arm(arm), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .force_trig(force_trig),
        .post_count(post_count),
        .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_result(rd_result),
        .armed(armed), .done(done), .fill_count(fill_count), .trig_idx(trig_idx)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input logic [XLEN-1:0] pc);
        entry_t e;
        e.pc    = pc;
        e.instr = pc ^ 32'hA5A5_0013;
        e.res   = pc + 32'd1000;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [XLEN-1:0] pc);
        entry_t e;
        e = mk(pc);
        trace_valid  = 1'b1;
        trace_pc     = e.pc;
        trace_instr  = e.instr;
        trace_result = e.res;
        tick();
        trace_valid  = 1'b0;
    endtask

    task automatic do_arm(input logic [AW-1:0] pc_cnt);
        post_count = pc_cnt;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // One read request; result must appear exactly one cycle later.
    task automatic rd(input int idx, input entry_t exp);
        entry_t e;
        sb.push_back(exp);
        rd_en  = 1'b1;
        rd_idx = AW'(idx);
        tick();
        rd_en  = 1'b0;
        chk($sformatf("rd_valid[%0d]", idx), {31'd0, rd_valid}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (rd_valid) begin
                chk($sformatf("rd_pc[%0d]", idx), rd_pc, e.pc);
                chk($sformatf("rd_instr[%0d]", idx), rd_instr, e.instr);
                chk($sformatf("rd_result[%0d]", idx), rd_result, e.res);
            end
        end
    endtask

    initial begin
        entry_t zero_e;
        zero_e.pc = '0; zero_e.instr = '0; zero_e.res = '0;
        reset = 1'b1; trace_valid = 1'b0; trace_pc = '0; trace_instr = '0;
        trace_result = '0; arm = 1'b0; trig_pc_en = 1'b0; trig_pc = '0;
        force_trig = 1'b0; post_count = '0; rd_en = 1'b0; rd_idx = '0;

        // Reset state
        #3;
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fill", {27'd0, fill_count}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_trig_idx", {28'd0, trig_idx}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // No-wrap capture, trigger on PC 8, two post entries
        trig_pc_en = 1'b1; trig_pc = 32'd8;
        do_arm(4'd2);
        chk("t2_armed", {31'd0, armed}, 32'd1);
        chk("t2_fill0", {27'd0, fill_count}, 32'd0);
        for (int k = 0; k < 4; k++) send(32'(4 * k));
        chk("t2_not_done", {31'd0, done}, 32'd0);
        send(32'd16);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_armed_off", {31'd0, armed}, 32'd0);
        chk("t2_fill", {27'd0, fill_count}, 32'd5);
        chk("t2_trig_idx", {28'd0, trig_idx}, 32'd2);
        for (int i = 0; i < 5; i++) rd(i, mk(32'(4 * i)));
        tick();
        chk("t2_rd_pulse", {31'd0, rd_valid}, 32'd0);

        // Out-of-range read returns zero data with rd_valid
        rd(5, zero_e);

        // Wrapping capture: 40 retires, trigger at PC 100, three post entries
        trig_pc = 32'd100;
        do_arm(4'd3);
        for (int k = 0; k < 40; k++) send(32'(4 * k));
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_fill", {27'd0, fill_count}, 32'd16);
        chk("t3_trig_idx", {28'd0, trig_idx}, 32'd12);
        rd(0, mk(32'd52));
        rd(15, mk(32'd112));
        rd(12, mk(32'd100));

        // arm with matching retire and read in the same cycle: arm wins
        post_count = 4'd3;
        arm = 1'b1; rd_en = 1'b1; rd_idx = '0;
        trace_valid = 1'b1; trace_pc = 32'd100;
        tick();
        arm = 1'b0; rd_en = 1'b0; trace_valid = 1'b0;
        chk("t5_armed", {31'd0, armed}, 32'd1);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_fill", {27'd0, fill_count}, 32'd0);
        chk("t5_rd_dropped", {31'd0, rd_valid}, 32'd0);

        // Read while ARMED is ignored
        rd_en = 1'b1; rd_idx = '0;
        tick();
        rd_en = 1'b0;
        chk("t6_rd_armed", {31'd0, rd_valid}, 32'd0);

        // Forced trigger held pending across idle cycles
        trig_pc_en = 1'b0;
        do_arm(4'd0);
        send(32'd300);
        send(32'd304);
        force_trig = 1'b1;
        tick(); tick(); tick();
        force_trig = 1'b0;
        chk("t4_still_armed", {31'd0, armed}, 32'd1);
        chk("t4_not_done", {31'd0, done}, 32'd0);
        chk("t4_fill2", {27'd0, fill_count}, 32'd2);
        send(32'd308);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_fill3", {27'd0, fill_count}, 32'd3);
        chk("t4_trig_idx", {28'd0, trig_idx}, 32'd2);
        send(32'd312);
        chk("t4_frozen_fill", {27'd0, fill_count}, 32'd3);
        rd(2, mk(32'd308));

        // Re-arm from DONE clears the buffer
        do_arm(4'd0);
        chk("rearm_fill", {27'd0, fill_count}, 32'd0);
        chk("rearm_done", {31'd0, done}, 32'd0);

        // Asynchronous reset in the middle of POST
        trig_pc_en = 1'b1; trig_pc = 32'd4;
        do_arm(4'd5);
        send(32'd0);
        send(32'd4);
        send(32'd8);
        chk("t1_pre_armed", {31'd0, armed}, 32'd1);
        chk("t1_pre_fill", {27'd0, fill_count}, 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("t1_armed", {31'd0, armed}, 32'd0);
        chk("t1_done", {31'd0, done}, 32'd0);
        chk("t1_fill", {27'd0, fill_count}, 32'd0);
        chk("t1_rd_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t1_idle_armed", {31'd0, armed}, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
